// File: rtl/cpsr_flag_sched.sv
// -----------------------------------------------------------------------------
// cpsr_flag_sched
// Scoreboard and write sequencer for the CPSR condition flags (N,Z,C,V).
// It counts in-flight flag writers per flag, stalls issue of instructions that
// would read a flag that is still pending, and shares the cpsr32 flag write
// port between ALU writeback (always wins) and MSR-style software writes.
//
// Flag order everywhere: bit3=N, bit2=Z, bit1=C, bit0=V.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   issue_valid     instruction presented at issue
//   issue_setmask   flags the instruction will write
//   issue_condmask  flags its condition reads (0 = AL)
//   issue_stall     hold the issue stage this cycle (combinational)
//   wb_valid        ALU flag writeback this cycle
//   wb_mask         flags written at writeback
//   wb_flags        flag values written at writeback
//   msr_req         software flag-write request, held until msr_ack
//   msr_mask        flags to write, stable while msr_req
//   msr_flags       values, stable while msr_req
//   msr_ack         one-cycle pulse: MSR write performed (registered)
//   should_set_cpsr per-flag write enable to cpsr32
//   cpsrwd          flag write data to cpsr32
//   pending         bit i = pending counter i nonzero
//
// Build option: FLAG_FWD_EN
//   Defined   - a flag whose last pending writer writes back this cycle is not
//               treated as busy (decode uses the forwarded wb_flags).
//   Undefined - a flag is busy while its counter is nonzero, costing one
//               bubble after the last writeback.
// -----------------------------------------------------------------------------
module cpsr_flag_sched #(
   parameter int FLAGS_W = 4,
   parameter int CNT_W   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               issue_valid,
   input  logic [FLAGS_W-1:0] issue_setmask,
   input  logic [FLAGS_W-1:0] issue_condmask,
   output logic               issue_stall,
   input  logic               wb_valid,
   input  logic [FLAGS_W-1:0] wb_mask,
   input  logic [FLAGS_W-1:0] wb_flags,
   input  logic               msr_req,
   input  logic [FLAGS_W-1:0] msr_mask,
   input  logic [FLAGS_W-1:0] msr_flags,
   output logic               msr_ack,
   output logic [FLAGS_W-1:0] should_set_cpsr,
   output logic [FLAGS_W-1:0] cpsrwd,
   output logic [FLAGS_W-1:0] pending
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_WRITE = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   logic [CNT_W-1:0]   cnt_r [FLAGS_W];
   state_t             state_r;
   logic               msr_ack_r;

   logic [FLAGS_W-1:0] pending_s;
   logic [FLAGS_W-1:0] busy_s;
   logic [FLAGS_W-1:0] sat_s;
   logic [FLAGS_W-1:0] wb_hit_s;
   logic               msr_active_s;
   logic               msr_block_s;
   logic               stall_s;
   logic               accept_s;
   logic               drain_done_s;

   // Per-flag status derived from the pending counters.
   always_comb begin
      pending_s = {FLAGS_W{1'b0}};
      busy_s    = {FLAGS_W{1'b0}};
      sat_s     = {FLAGS_W{1'b0}};
      wb_hit_s  = {FLAGS_W{1'b0}};
      for (int i = 0; i < FLAGS_W; i++) begin
         wb_hit_s[i]  = wb_valid & wb_mask[i];
         pending_s[i] = (cnt_r[i] != CNT_ZERO);
         sat_s[i]     = (cnt_r[i] == CNT_MAX);
`ifdef FLAG_FWD_EN
         // The last outstanding writer retiring this cycle releases the flag.
         busy_s[i]    = pending_s[i] & ~((cnt_r[i] == CNT_ONE) & wb_hit_s[i]);
`else
         busy_s[i]    = pending_s[i];
`endif
      end
   end

   // Issue stall and accept; the MSR only blocks instructions touching its flags.
   always_comb begin
      msr_active_s = (state_r == ST_DRAIN) | (state_r == ST_WRITE);
      msr_block_s  = msr_active_s & (|((issue_setmask | issue_condmask) & msr_mask));
      stall_s      = issue_valid & ((|(issue_condmask & busy_s)) |
                                    (|(issue_setmask & sat_s)) |
                                    msr_block_s);
      accept_s     = issue_valid & ~stall_s;
      drain_done_s = ~(|(msr_mask & pending_s)) & ~wb_valid;
   end

   // Pending counters: +1 on accepted writer, -1 on writeback, never underflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FLAGS_W; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
      end else begin
         for (int i = 0; i < FLAGS_W; i++) begin
            if (accept_s & issue_setmask[i] & ~wb_hit_s[i]) begin
               cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end else if (wb_hit_s[i] & ~(accept_s & issue_setmask[i]) & pending_s[i]) begin
               cnt_r[i] <= cnt_r[i] - CNT_ONE;
            end else begin
               cnt_r[i] <= cnt_r[i];
            end
         end
      end
   end

   // MSR sequencer: drain conflicting writers, take a free port cycle, then ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         msr_ack_r <= 1'b0;
      end else begin
         msr_ack_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (msr_req) state_r <= ST_DRAIN;
               else         state_r <= ST_IDLE;
            end
            ST_DRAIN: begin
               if (drain_done_s) state_r <= ST_WRITE;
               else              state_r <= ST_DRAIN;
            end
            ST_WRITE: begin
               // ALU owns the port this cycle; retry next cycle.
               if (wb_valid) begin
                  state_r <= ST_WRITE;
               end else begin
                  state_r   <= ST_ACK;
                  msr_ack_r <= 1'b1;
               end
            end
            ST_ACK: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Flag write port: ALU writeback first, then a pending MSR write.
   always_comb begin
      should_set_cpsr = {FLAGS_W{1'b0}};
      cpsrwd          = {FLAGS_W{1'b0}};
      if (reset) begin
         should_set_cpsr = {FLAGS_W{1'b0}};
         cpsrwd          = {FLAGS_W{1'b0}};
      end else if (wb_valid) begin
         should_set_cpsr = wb_mask;
         cpsrwd          = wb_flags;
      end else if (state_r == ST_WRITE) begin
         should_set_cpsr = msr_mask;
         cpsrwd          = msr_flags;
      end else begin
         should_set_cpsr = {FLAGS_W{1'b0}};
         cpsrwd          = {FLAGS_W{1'b0}};
      end
   end

   assign issue_stall = stall_s & ~reset;
   assign msr_ack     = msr_ack_r;
   assign pending     = pending_s;

endmodule

// File: tb/tb_cpsr_flag_sched.sv
module tb_cpsr_flag_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       issue_valid;
   logic [3:0] issue_setmask, issue_condmask;
   logic       issue_stall;
   logic       wb_valid;
   logic [3:0] wb_mask, wb_flags;
   logic       msr_req;
   logic [3:0] msr_mask, msr_flags;
   logic       msr_ack;
   logic [3:0] should_set_cpsr, cpsrwd, pending;

   int total = 0;
   int bad   = 0;

   cpsr_flag_sched dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_setmask(issue_setmask),
      .issue_condmask(issue_condmask), .issue_stall(issue_stall),
      .wb_valid(wb_valid), .wb_mask(wb_mask), .wb_flags(wb_flags),
      .msr_req(msr_req), .msr_mask(msr_mask), .msr_flags(msr_flags),
      .msr_ack(msr_ack), .should_set_cpsr(should_set_cpsr),
      .cpsrwd(cpsrwd), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic iss(input logic v, input logic [3:0] s, input logic [3:0] c);
      issue_valid = v; issue_setmask = s; issue_condmask = c;
   endtask

   task automatic wb(input logic v, input logic [3:0] m, input logic [3:0] f);
      wb_valid = v; wb_mask = m; wb_flags = f;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   task automatic nxt;
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      iss(1'b0, 4'b0000, 4'b0000);
      wb(1'b0, 4'b0000, 4'b0000);
      msr_req = 1'b0; msr_mask = 4'b0000; msr_flags = 4'b0000;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      mid;
      chk("rst_pending", {4'b0, pending}, 8'h00);
      chk("rst_ack", {7'b0, msr_ack}, 8'h00);
      chk("rst_set", {4'b0, should_set_cpsr}, 8'h00);
      nxt;

      // Test 1: load counters to 2, then async reset mid-cycle
      iss(1'b1, 4'b1111, 4'b0000); mid; chk("t1_acc0", {7'b0, issue_stall}, 8'h00); nxt;
      mid; chk("t1_acc1", {7'b0, issue_stall}, 8'h00); nxt;
      iss(1'b1, 4'b0000, 4'b1111); wb(1'b1, 4'b1111, 4'b1010);
      mid;
      chk("t1_pend", {4'b0, pending}, 8'h0f);
      chk("t1_stall", {7'b0, issue_stall}, 8'h01);
      chk("t1_wbset", {4'b0, should_set_cpsr}, 8'h0f);
      chk("t1_wbd", {4'b0, cpsrwd}, 8'h0a);
      #1 reset = 1'b1;
      #1;
      chk("t1_rpend", {4'b0, pending}, 8'h00);
      chk("t1_rset", {4'b0, should_set_cpsr}, 8'h00);
      chk("t1_rd", {4'b0, cpsrwd}, 8'h00);
      chk("t1_rstall", {7'b0, issue_stall}, 8'h00);
      nxt;
      reset = 1'b0;
      iss(1'b0, 4'b0000, 4'b0000); wb(1'b0, 4'b0000, 4'b0000);
      mid; chk("t1_after", {4'b0, pending}, 8'h00); nxt;

      // Test 2: NZ writer, then EQ reader, writeback at cycle 3
      iss(1'b1, 4'b1100, 4'b0000); mid; chk("t2_c0", {7'b0, issue_stall}, 8'h00); nxt;
      iss(1'b1, 4'b0000, 4'b0100); mid; chk("t2_c1", {7'b0, issue_stall}, 8'h01); nxt;
      mid; chk("t2_c2", {7'b0, issue_stall}, 8'h01); nxt;
      wb(1'b1, 4'b1100, 4'b0100);
      mid;
`ifdef FLAG_FWD_EN
      chk("t2_c3", {7'b0, issue_stall}, 8'h00);
`else
      chk("t2_c3", {7'b0, issue_stall}, 8'h01);
`endif
      chk("t2_set", {4'b0, should_set_cpsr}, 8'h0c);
      chk("t2_d", {4'b0, cpsrwd}, 8'h04);
      nxt;
      wb(1'b0, 4'b0000, 4'b0000);
      mid; chk("t2_c4", {7'b0, issue_stall}, 8'h00); chk("t2_pend", {4'b0, pending}, 8'h00); nxt;
      iss(1'b0, 4'b0000, 4'b0000);

      // Test 3: saturate C counter at 3
      iss(1'b1, 4'b0010, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         mid; chk("t3_fill", {7'b0, issue_stall}, 8'h00); nxt;
      end
      wb(1'b1, 4'b0010, 4'b0010);
      mid; chk("t3_pend", {4'b0, pending}, 8'h02); chk("t3_sat", {7'b0, issue_stall}, 8'h01); nxt;
      wb(1'b0, 4'b0000, 4'b0000);
      mid; chk("t3_next", {7'b0, issue_stall}, 8'h00); nxt;
      iss(1'b0, 4'b0000, 4'b0000);
      wb(1'b1, 4'b0010, 4'b0000);
      repeat (3) nxt;
      wb(1'b0, 4'b0000, 4'b0000);
      mid; chk("t3_empty", {4'b0, pending}, 8'h00); nxt;

      // Test 4: MSR V write waits for V writer
      iss(1'b1, 4'b0001, 4'b0000); mid; chk("t4_acc", {7'b0, issue_stall}, 8'h00); nxt;
      iss(1'b0, 4'b0000, 4'b0000);
      msr_req = 1'b1; msr_mask = 4'b0001; msr_flags = 4'b0001;
      nxt;
      iss(1'b1, 4'b0001, 4'b0000);
      mid;
      chk("t4_block", {7'b0, issue_stall}, 8'h01);
      chk("t4_noset", {4'b0, should_set_cpsr}, 8'h00);
      nxt;
      iss(1'b0, 4'b0000, 4'b0000); wb(1'b1, 4'b0001, 4'b0000);
      mid; chk("t4_wbset", {4'b0, should_set_cpsr}, 8'h01); chk("t4_wbd", {4'b0, cpsrwd}, 8'h00); nxt;
      wb(1'b0, 4'b0000, 4'b0000);
      mid; chk("t4_drain", {4'b0, should_set_cpsr}, 8'h00); nxt;
      mid;
      chk("t4_wset", {4'b0, should_set_cpsr}, 8'h01);
      chk("t4_wd", {4'b0, cpsrwd}, 8'h01);
      chk("t4_noack", {7'b0, msr_ack}, 8'h00);
      nxt;
      msr_req = 1'b0;
      mid; chk("t4_ack", {7'b0, msr_ack}, 8'h01); chk("t4_aset", {4'b0, should_set_cpsr}, 8'h00); nxt;
      mid; chk("t4_ackoff", {7'b0, msr_ack}, 8'h00); nxt;

      // Test 5: ALU steals the port while MSR is in WRITE
      msr_req = 1'b1; msr_mask = 4'b1010; msr_flags = 4'b1000;
      nxt;
      iss(1'b1, 4'b0000, 4'b0010);
      mid; chk("t5_block", {7'b0, issue_stall}, 8'h01); nxt;
      wb(1'b1, 4'b1000, 4'b0000);
      mid;
      chk("t5_aluset", {4'b0, should_set_cpsr}, 8'h08);
      chk("t5_alud", {4'b0, cpsrwd}, 8'h00);
      chk("t5_wblock", {7'b0, issue_stall}, 8'h01);
      nxt;
      wb(1'b0, 4'b0000, 4'b0000);
      mid;
      chk("t5_mset", {4'b0, should_set_cpsr}, 8'h0a);
      chk("t5_md", {4'b0, cpsrwd}, 8'h08);
      chk("t5_noack", {7'b0, msr_ack}, 8'h00);
      nxt;
      msr_req = 1'b0;
      mid; chk("t5_ack", {7'b0, msr_ack}, 8'h01); chk("t5_free", {7'b0, issue_stall}, 8'h00); nxt;
      iss(1'b0, 4'b0000, 4'b0000);

      // Test 6: simultaneous accept and writeback keep counters at 1
      iss(1'b1, 4'b1111, 4'b0000); nxt;
      wb(1'b1, 4'b1111, 4'b0101);
      mid;
      chk("t6_stall", {7'b0, issue_stall}, 8'h00);
      chk("t6_set", {4'b0, should_set_cpsr}, 8'h0f);
      chk("t6_d", {4'b0, cpsrwd}, 8'h05);
      nxt;
      iss(1'b0, 4'b0000, 4'b0000); wb(1'b0, 4'b0000, 4'b0000);
      mid; chk("t6_pend", {4'b0, pending}, 8'h0f); nxt;
      wb(1'b1, 4'b1111, 4'b0000); nxt;
      wb(1'b0, 4'b0000, 4'b0000);
      mid; chk("t6_clear", {4'b0, pending}, 8'h00); nxt;

      // Zero-mask MSR still walks the sequencer and acks
      msr_req = 1'b1; msr_mask = 4'b0000; msr_flags = 4'b1111;
      nxt;
      nxt;
      mid; chk("t7_wset", {4'b0, should_set_cpsr}, 8'h00); chk("t7_noack", {7'b0, msr_ack}, 8'h00); nxt;
      msr_req = 1'b0;
      mid; chk("t7_ack", {7'b0, msr_ack}, 8'h01); nxt;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
